alu_seq: RTL

Operand/command sequencer placed directly upstream of the ALU. It accepts one operation at a time over a valid/ready handshake and registers the operands and opcode onto the ALU inputs. For the multi-cycle mod operation it pulses `alu_start` and waits for `alu_done`. It then captures `res` and `carry` into an output register that is held until the consumer accepts it.

---
 rtl/alu_seq_pkg.sv | 23 ++
 rtl/alu_seq_wdog.sv | 31 +++
 rtl/alu_seq.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state encoding and defaults for the ALU operand/command sequencer.
package alu_seq_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_XOR = 3'b010;
  localparam logic [2:0] OP_NOR = 3'b011;
  localparam logic [2:0] OP_LT  = 3'b100;
  localparam logic [2:0] OP_ADD = 3'b101;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_MOD = 3'b111;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 64;

  typedef enum logic [2:0] {
    StIdle,
    StExec,
    StStart,
    StWait,
    StResp
  } state_e;

endpackage

// File: rtl/alu_seq_wdog.sv
// Loadable down-counter guarding the mod wait; expired is high once the count reaches zero.
// Loading CYCLES-1 on WAIT entry makes the CYCLES-th WAIT cycle the one that sees expiry.
module alu_seq_wdog #(
  parameter int unsigned CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CntW-1:0] LoadVal = CntW'(CYCLES - 1);

  logic [CntW-1:0] cnt_q;

  // Reload on entry, then count down while enabled, saturating at zero.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= LoadVal;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/alu_seq.sv
// Operand/command sequencer in front of the ALU: one command at a time, registered ALU
// inputs, start/done handshake for MOD, and a held result register.
// Optional mod watchdog compiled in with `define ALU_SEQ_TIMEOUT_EN.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_carry,
  output logic             out_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  output logic             alu_start,
  input  logic [WIDTH-1:0] alu_res,
  input  logic             alu_done,
  input  logic             alu_carry,
  output logic [15:0]      op_count
);

  state_e state_q, state_d;

  logic [WIDTH-1:0] alu_a_q, alu_b_q, out_res_q;
  logic [2:0]       alu_op_q;
  logic             out_carry_q;
  logic [15:0]      op_count_q;
  logic             timeout;

`ifdef ALU_SEQ_TIMEOUT_EN
  logic wdog_expired;
  logic out_err_q;

  alu_seq_wdog #(
    .CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .load   (state_q == StStart),
    .en     (state_q == StWait),
    .expired(wdog_expired)
  );

  assign timeout = wdog_expired;

  // Error flag set on a mod timeout, cleared when the result is consumed.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_err_q <= 1'b0;
    end else if ((state_q == StWait) && !alu_done && timeout) begin
      out_err_q <= 1'b1;
    end else if ((state_q == StResp) && out_ready) begin
      out_err_q <= 1'b0;
    end
  end

  assign out_err = out_err_q;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
  assign out_err = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; done is only looked at in WAIT so a stale done cannot skip the wait.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (in_valid) state_d = (in_op == OP_MOD) ? StStart : StExec;
      StExec:  state_d = StResp;
      StStart: state_d = StWait;
      StWait:  if (alu_done || timeout) state_d = StResp;
      StResp:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Operand latch on accept, result capture, and completed-op counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_op_q    <= OP_AND;
      out_res_q   <= '0;
      out_carry_q <= 1'b0;
      op_count_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            alu_a_q  <= in_a;
            alu_b_q  <= in_b;
            alu_op_q <= in_op;
          end
        end
        StExec: begin
          out_res_q   <= alu_res;
          out_carry_q <= (alu_op_q == OP_ADD) && alu_carry;
        end
        StWait: begin
          if (alu_done) begin
            out_res_q   <= alu_res;
            out_carry_q <= 1'b0;
          end else if (timeout) begin
            out_res_q   <= '0;
            out_carry_q <= 1'b0;
          end
        end
        StResp: begin
          if (out_ready) op_count_q <= op_count_q + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StResp);
  assign alu_start = (state_q == StStart);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign out_res   = out_res_q;
  assign out_carry = out_carry_q;
  assign op_count  = op_count_q;

endmodule
